// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the wide-ALU operand sequencer.
package alu_seq_pkg;

    localparam int ALU_WIDTH = 512;
    localparam int ALU_BUS_W = 32;
    localparam int ALU_BEATS = ALU_WIDTH / ALU_BUS_W;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_wide_word_reg.sv
// WIDTH-bit register built from BUS_W-bit words: single-word indexed write,
// full-width parallel load (load wins over word write), indexed word read
// and a full-width view.
module wide_word_reg
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BUS_W = ALU_BUS_W,
    localparam int WORDS = WIDTH / BUS_W,
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [BUS_W-1:0] wr_data_i,
    input  logic             ld_en_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [BUS_W-1:0] rd_data_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WORDS-1:0][BUS_W-1:0] words;

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        logic [BUS_W-1:0] word_q;

        // One storage word: cleared on reset, full load beats indexed write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (ld_en_i) begin
                word_q <= ld_data_i[w*BUS_W +: BUS_W];
            end else if (wr_en_i && (wr_idx_i == IDX_W'(w))) begin
                word_q <= wr_data_i;
            end
        end

        assign words[w] = word_q;
    end

    assign rd_data_o = words[rd_idx_i];
    assign q_o       = words;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Narrow-bus front end for the wide signed ALU: gathers A, B and opcode from
// a BUS_W valid/ready stream, holds them on the ALU ports, waits ALU_LAT
// cycles, captures {D,C} and streams the 2*WIDTH result back out.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int BUS_W   = ALU_BUS_W,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BUS_W-1:0] in_data_i,
    input  logic             in_op_i,
    output logic             alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_c_i,
    input  logic [WIDTH-1:0] alu_d_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BUS_W-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o
);

    localparam int BEATS   = WIDTH / BUS_W;
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int RBEAT_W = $clog2(2 * BEATS);
    localparam int CNT_W   = $clog2(ALU_LAT + 1);

    seq_state_t         state_q, state_d;
    logic               run_q;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [RBEAT_W-1:0] rbeat_q, rbeat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_stage_q, op_stage_d;
    logic               alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [BUS_W-1:0]   out_data_q, out_data_d;

    logic               in_hs, out_hs, beat_last;
    logic               wr_a, wr_b, capture;
    logic [WIDTH-1:0]   stage_a_q, stage_b_q, b_full;
    logic [2*WIDTH-1:0] res_q;
    logic [RBEAT_W-1:0] res_rd_idx;
    logic [BUS_W-1:0]   sa_rd, sb_rd, res_rd;
    logic               unused_rd;

    wide_word_reg #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_a),
        .wr_idx_i  (beat_q),
        .wr_data_i (in_data_i),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_idx_i  ('0),
        .rd_data_o (sa_rd),
        .q_o       (stage_a_q)
    );

    wide_word_reg #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_stage_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_b),
        .wr_idx_i  (beat_q),
        .wr_data_i (in_data_i),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_idx_i  ('0),
        .rd_data_o (sb_rd),
        .q_o       (stage_b_q)
    );

    // Result words 0..BEATS-1 hold C, BEATS..2*BEATS-1 hold D.
    wide_word_reg #(.WIDTH(2 * WIDTH), .BUS_W(BUS_W)) u_result (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0),
        .ld_en_i   (capture),
        .ld_data_i ({alu_d_i, alu_c_i}),
        .rd_idx_i  (res_rd_idx),
        .rd_data_o (res_rd),
        .q_o       (res_q)
    );

    // Only the full views of the staging registers and the word view of
    // the result are consumed.
    assign unused_rd = ^{sa_rd, sb_rd, res_q};

    // out_data is registered, so prefetch the word after the one on the bus.
    assign res_rd_idx = rbeat_q + 1'b1;

    assign in_ready_o  = run_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign out_valid_o = (state_q == DRAIN);
    assign out_last_o  = out_valid_o && (rbeat_q == RBEAT_W'(2 * BEATS - 1));
    assign busy_o      = (state_q == EXEC) || (state_q == DRAIN);

    assign in_hs     = in_valid_i && in_ready_o;
    assign out_hs    = out_valid_o && out_ready_i;
    assign beat_last = (beat_q == BEAT_W'(BEATS - 1));

    assign alu_op_o   = alu_op_q;
    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign out_data_o = out_data_q;

    // B as it will be once the top word arriving this cycle is written.
    always_comb begin
        b_full = stage_b_q;
        b_full[(BEATS-1)*BUS_W +: BUS_W] = in_data_i;
    end

    // Next-state and datapath control for load / execute / drain.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rbeat_d    = rbeat_q;
        cnt_d      = cnt_q;
        op_stage_d = op_stage_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        out_data_d = out_data_q;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        capture    = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (in_hs) begin
                    wr_a   = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '0) op_stage_d = in_op_i;
                    if (beat_last) begin
                        beat_d  = '0;
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    wr_b   = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        beat_d   = '0;
                        alu_a_d  = stage_a_q;
                        alu_b_d  = b_full;
                        alu_op_d = op_stage_q;
                        cnt_d    = CNT_W'(ALU_LAT);
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture    = 1'b1;
                    rbeat_d    = '0;
                    out_data_d = alu_c_i[BUS_W-1:0];
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (out_last_o) begin
                        rbeat_d = '0;
                        state_d = LOAD_A;
                    end else begin
                        rbeat_d    = rbeat_q + 1'b1;
                        out_data_d = res_rd;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // State, counters and ALU-facing operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            run_q      <= 1'b0;
            beat_q     <= '0;
            rbeat_q    <= '0;
            cnt_q      <= '0;
            op_stage_q <= 1'b0;
            alu_op_q   <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            beat_q     <= beat_d;
            rbeat_q    <= rbeat_d;
            cnt_q      <= cnt_d;
            op_stage_q <= op_stage_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: stimulus pushes the expected 32 result words per
// operation; an independent monitor pops and compares on each output beat.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    localparam int W  = ALU_WIDTH;
    localparam int BW = ALU_BUS_W;
    localparam int NB = ALU_BEATS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          in_op = 1'b0;
    logic          alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_c, alu_d;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    bit bp_en = 1'b0;

    logic [BW-1:0] exp_data_q[$];
    bit            exp_last_q[$];
    logic [W-1:0]  exp_a_q[$];
    logic [W-1:0]  exp_b_q[$];
    logic          exp_op_q[$];

    alu_operand_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_op_i     (in_op),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_c_i     (alu_c),
        .alu_d_i     (alu_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Exact signed result of the ALU operation, 2*W bits: {D, C}.
    function automatic logic [2*W-1:0] alu_ref(input logic op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return op ? (sa * sb) : (sa + sb);
    endfunction

    // Stand-in for the ALU attached to the sequencer.
    assign {alu_d, alu_c} = alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        int mode;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < NB; i++) v[i*BW +: BW] = $urandom;
        if (mode == 1) v = W'(v[15:0]);
        else if (mode == 2) v = ~W'(v[15:0]);
        return v;
    endfunction

    // Presents one word starting at a negedge; returns at the negedge after
    // the edge that accepted it.
    task automatic send_word(input logic [BW-1:0] d, input logic op, input bit gaps);
        int g = 0;
        while (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        while (!in_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit gaps);
        logic [2*W-1:0] r;
        r = alu_ref(op, a, b);
        for (int i = 0; i < 2 * NB; i++) begin
            exp_data_q.push_back(r[i*BW +: BW]);
            exp_last_q.push_back(i == 2 * NB - 1);
        end
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
        exp_op_q.push_back(op);
        // Opcode is only meaningful on the first A beat; scramble it elsewhere.
        for (int i = 0; i < NB; i++) send_word(a[i*BW +: BW], (i == 0) ? op : 1'($urandom), gaps);
        for (int i = 0; i < NB; i++) send_word(b[i*BW +: BW], 1'($urandom), gaps);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_data_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (exp_data_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_data_q.size());
        end
    endtask

    // Monitor: drives out_ready and checks every presented result word.
    always @(negedge clk) begin
        if (!rst_n) begin
            out_ready = 1'b0;
        end else begin
            out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid) begin
                if (exp_data_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h with nothing expected", out_data);
                end else begin
                    chk("out_data", W'(out_data), W'(exp_data_q[0]));
                    chk("out_last", W'(out_last), W'(exp_last_q[0]));
                    chk("alu_a_hold", alu_a, exp_a_q[0]);
                    chk("alu_b_hold", alu_b, exp_b_q[0]);
                    chk("alu_op_hold", W'(alu_op), W'(exp_op_q[0]));
                    if (out_ready) begin
                        if (exp_last_q[0]) begin
                            void'(exp_a_q.pop_front());
                            void'(exp_b_q.pop_front());
                            void'(exp_op_q.pop_front());
                        end
                        void'(exp_data_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic         op;

        // Reset held with traffic pending on the input.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = '1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctrl", W'({in_ready, out_valid, out_last, busy, alu_op}), '0);
            chk("rst_out_data", W'(out_data), '0);
            chk("rst_alu_a", alu_a, '0);
            chk("rst_alu_b", alu_b, '0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", W'(in_ready), W'(1));

        // 3 + 4, then latency: EXEC right after last B beat, output one edge later.
        run_op(OP_ADD, W'(3), W'(4), 1'b0);
        chk("exec_busy", W'({busy, out_valid}), W'(2'b10));
        @(negedge clk);
        chk("drain_valid", W'({busy, out_valid}), W'(2'b11));

        // 2^32 * 3
        a = '0;
        a[32] = 1'b1;
        run_op(OP_MUL, a, W'(3), 1'b0);

        // -1 + 0: C and D both all ones.
        run_op(OP_ADD, '1, '0, 1'b0);

        // Random operands, each op once clean and once with gaps/backpressure.
        for (int k = 0; k < 5; k++) begin
            a  = rand_operand();
            b  = rand_operand();
            op = 1'($urandom);
            bp_en = 1'b0;
            run_op(op, a, b, 1'b0);
            wait_drain();
            bp_en = 1'b1;
            run_op(op, a, b, 1'b1);
            wait_drain();
        end
        bp_en = 1'b0;

        // Abort a load after 9 A beats; the following op must be unaffected.
        for (int i = 0; i < 9; i++) send_word($urandom, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_ctrl", W'({in_ready, busy, out_valid}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_ADD, W'(1), W'(1), 1'b0);
        wait_drain();
        @(negedge clk);
        chk("final_idle", W'({busy, out_valid, in_ready}), W'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Upstream/downstream sequencer for the 512-bit signed `alu`. It assembles two 512-bit operands and an opcode from a 32-bit valid/ready input stream and presents them to the ALU, held stable. After a fixed settle latency it captures the ALU's `C` and `D` outputs and drains them as a 32-bit valid/ready output stream. This lets the wide ALU sit behind a narrow bus.

## Interface
- `WIDTH`, 512, operand and result-half width; must equal the ALU width.
- `BUS_W`, 32, stream word width; `WIDTH % BUS_W == 0`.
- `ALU_LAT`, 1, cycles from operand update to `C`/`D` capture; minimum 1.
- Derived `BEATS = WIDTH/BUS_W` (16).

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  sequencer accepts input word.
- `in_data`  in  BUS_W  operand word, least-significant word first.
- `in_op`  in  1  opcode (1 = multiply, 0 = add); sampled on first A beat only.
- `alu_op`  out  1  to ALU `operation`.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `A`/`B`, signed.
- `alu_c`, `alu_d`  in  WIDTH  from ALU `C`/`D`.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  consumer accepts result word.
- `out_data`  out  BUS_W  result word.
- `out_last`  out  1  high with final (32nd) result word.
- `busy`  out  1  high in EXEC and DRAIN.

## Operation
- States: LOAD_A, LOAD_B, EXEC, DRAIN. Reset state is LOAD_A.
- LOAD_A: `in_ready`=1. Each handshake (`in_valid & in_ready`) writes the word into staging A at index `beat`, then increments `beat`. The `in_op` value is latched into staged op on beat 0. After beat BEATS-1, go to LOAD_B with `beat`=0.
- LOAD_B: same as LOAD_A, into staging B. On the final beat the same edge does three things:
  - copies staged A, B and op to `alu_a`, `alu_b`, `alu_op`;
  - loads the settle counter with ALU_LAT;
  - enters EXEC.
- EXEC: `in_ready`=0. The counter decrements each cycle. On the edge where counter==1, capture `alu_c` into result words 0..15 and `alu_d` into words 16..31, then enter DRAIN.
- DRAIN: `out_data` = result word `rbeat` (registered). `out_valid`=1, and data holds stable until `out_ready`. Each handshake advances `rbeat`. `out_last`=1 when `rbeat`==2*BEATS-1. After the last handshake, go to LOAD_A.
- `alu_a`, `alu_b` and `alu_op` change only on entry to EXEC; they hold through DRAIN and the next load.
- No sign handling in this block: words are raw two's-complement slices.
- Reset values: `in_ready`=0 while `rst_n` low, 1 after (LOAD_A). All other outputs are 0: `alu_*`, `out_data`, `out_valid`, `out_last`, `busy`. Staging, counters and result registers are also cleared.

## Timing
- `in_ready`, `out_valid`, `out_last` and `busy` decode combinationally from registered state; `out_data` is registered.
- `in_valid` low mid-operand: `beat` holds, no timeout.
- Latency: last B beat accepted at edge t → EXEC from t; capture at edge t+ALU_LAT; `out_valid` high from t+ALU_LAT.
- Throughput with both streams always ready: 32 in + ALU_LAT + 32 out cycles per operation. No overlap of load and drain.
- `out_ready` low: word and `out_valid` held indefinitely.
- `in_valid` during EXEC/DRAIN: ignored (`in_ready`=0), nothing consumed.
- Reset asserted mid-operation: immediate return to LOAD_A. Partial operands and undrained results are discarded; outputs take reset values.

## Structure
- Package `alu_seq_pkg`:
  - state enum `seq_state_t`;
  - constants `ALU_WIDTH`=512, `ALU_BUS_W`=32, `ALU_BEATS`;
  - opcode constants `OP_ADD`=0, `OP_MUL`=1.
- Sub-module `wide_word_reg`: WIDTH-bit register with indexed BUS_W word write and word read. Instantiated for staging A, staging B and the result (2×WIDTH).
- Top holds the FSM and the `beat`, `rbeat` and settle counters.

## Test plan
- Reset: hold `rst_n` low 3 cycles with `in_valid`=1 → `in_ready`=0, all outputs 0. Release → `in_ready`=1 next cycle.
- Add: `in_op`=0, A words {3,0…}, B words {4,0…}, ALU attached, ALU_LAT=1 → 32 out words. Word 0 = 7, all others 0, `out_last` only on word 31.
- Multiply: `in_op`=1, A word1=1 (value 2^32), B word0=3 → out word1=3, all others 0.
- Signed add: A all 0xFFFFFFFF (−1), B=0 → words 0..15 all 0xFFFFFFFF (C=−1), and words 16..31 all 0xFFFFFFFF (D=sign extension).
- Backpressure/gaps:
  - random `in_valid` gaps and random `out_ready` → same result as the gap-free run;
  - `out_data` stable while `out_ready`=0;
  - `alu_a` unchanged during DRAIN.
- Reset mid-operation: assert `rst_n` low after 9 A beats, then run a full add of 1+1 → out word 0 = 2, no residue from the aborted load.
